pe_input: RTL and testbench
===========================

# pe_input

Router PE-injection port: the router-side receiver of the PE link. It accepts 64-bit packets from the local PE via a ready/send handshake into two single-entry virtual-channel buffers (even, odd). It decodes the direction bit of each packet and raises a level request toward the cw or ccw output arbiter, then releases the buffer on that arbiter's grant. It sits between the PE interface and the cw/ccw output-port arbiters, and uses the same polarity phasing as the rest of the router.

## Interface
- DATA_WIDTH, 64, packet width
- DIR_BIT, 62, header bit selecting direction (0 = cw, 1 = ccw)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- polarity  input  1  router phase; toggles every cycle at system level, treated as an arbitrary input here
- pesi  input  1  PE send; pedi valid this cycle
- pedi  input  DATA_WIDTH  PE data
- peri  output  1  router ready to accept a packet from the PE
- request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd  output  1 each  level request to the output arbiters
- grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd  input  1 each  arbiter has captured the buffer contents
- data_out_even, data_out_odd  output  DATA_WIDTH each  buffer contents, held stable while the matching request is high
- err_ovf  output  1  sticky flag: pesi seen while peri low

## Operation
- Two buffers, each with state EMPTY or FULL, plus a stored direction bit dir_e/dir_o.
- Phase rule:
  - polarity=0: PE writes the even buffer; the odd buffer forwards.
  - polarity=1: PE writes the odd buffer; the even buffer forwards.
- peri is combinational: peri = !rst & (polarity ? odd EMPTY : even EMPTY).
- Write:
  - Condition: posedge with pesi & peri.
  - The phase-selected buffer loads pedi, stores dir = pedi[DIR_BIT], and goes FULL.
  - No modification of packet contents.
- Request, combinational from registered state:
  - request_cw_even = even FULL & !dir_e & polarity.
  - request_ccw_even = even FULL & dir_e & polarity.
  - request_cw_odd = odd FULL & !dir_o & !polarity.
  - request_ccw_odd = odd FULL & dir_o & !polarity.
  - A full buffer therefore requests only during its forwarding phase and drops the request during its write phase.
- Release:
  - Condition: posedge where the buffer is FULL and the grant matching its stored direction and VC is high.
  - Effect: buffer goes EMPTY. data_out holds its last value.
  - A grant on the wrong direction, or to an EMPTY buffer, is ignored.
  - A grant is honoured regardless of the current polarity.
- Overflow:
  - Condition: posedge with pesi & !peri and not rst.
  - Effect: err_ovf is set and the packet is dropped. Buffer state is unchanged.
  - err_ovf is cleared only by rst.
- Write and release on the same edge can only hit different buffers, since a write requires EMPTY and a release requires FULL. Both take effect.

## Timing
- Reset values: both buffers EMPTY, data_out_even/odd = 0, dir bits 0, all requests 0, peri 0 while rst is high, err_ovf 0.
- Reset mid-operation discards buffered packets with no request or grant completion.
- Injection latency: pesi accepted at edge N → FULL at N+1. The request is visible in cycle N+1 if polarity has changed to the forwarding phase, otherwise in the first cycle with the forwarding polarity.
- With polarity toggling every cycle, the request appears 1 cycle after acceptance.
- Grant sampled at edge M → request low from M+1.
- The buffer may be rewritten at the first write-phase edge after M, giving a minimum of 2 cycles between packets on one VC.
- data_out changes only on a write edge. It is stable throughout request assertion, including across the downstream negedge capture.
- A PE streaming with pesi held high and polarity toggling is accepted on alternate VCs every cycle, as long as grants return within one cycle.

## Test plan
- Reset: assert rst 2 cycles with pesi=1 → peri=0, all requests 0, data_out 0, err_ovf 0 after release.
- Single cw inject:
  - Stimulus: polarity=0, pesi=1, pedi=64'h0000_0000_0000_00A5 (bit62=0) at edge 1.
  - Required: even FULL; cycle with polarity=1 shows request_cw_even=1, data_out_even=...A5.
  - Then grant_cw_even=1 for one edge → request 0 next cycle, peri=1 in the next polarity=0 cycle.
- ccw on odd: polarity=1, pedi=64'h4000_0000_0000_0003 → request_ccw_odd=1 only during polarity=0; grant_cw_odd pulse ignored (request stays 1); grant_ccw_odd releases.
- Overflow: fill even, withhold grants, polarity=0, pesi=1 → peri=0, err_ovf=1 next cycle, data_out_even unchanged, err_ovf stays 1 until rst.
- Back-to-back streaming: polarity toggling, pesi=1 continuously with values 1,2,3,4 (alternating direction), grants returned the cycle after each request → all four packets emerge in order on the correct request lines, err_ovf=0.
- Reset mid-operation: both buffers FULL with requests pending, assert rst one cycle → all requests 0, peri=1 in the following cycle, previously buffered packets never re-requested.

Source files
------------

// File: rtl/pe_input_if.sv
// rtl/pe_input_if.sv - PE link and output-arbiter signals of the router PE-injection port
interface pe_input_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  pesi;
    logic [DATA_WIDTH-1:0] pedi;
    logic                  peri;

    logic                  request_cw_even;
    logic                  request_cw_odd;
    logic                  request_ccw_even;
    logic                  request_ccw_odd;
    logic                  grant_cw_even;
    logic                  grant_cw_odd;
    logic                  grant_ccw_even;
    logic                  grant_ccw_odd;
    logic [DATA_WIDTH-1:0] data_out_even;
    logic [DATA_WIDTH-1:0] data_out_odd;
    logic                  err_ovf;

    // PE plus arbiter side: drives send/data/grants, observes the router outputs
    modport master (
        output pesi, pedi,
        output grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd,
        input  peri,
        input  request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd,
        input  data_out_even, data_out_odd, err_ovf
    );

    modport slave (
        input  pesi, pedi,
        input  grant_cw_even, grant_cw_odd, grant_ccw_even, grant_ccw_odd,
        output peri,
        output request_cw_even, request_cw_odd, request_ccw_even, request_ccw_odd,
        output data_out_even, data_out_odd, err_ovf
    );
endinterface

// File: rtl/pe_input.sv
// rtl/pe_input.sv - router PE-injection port with even/odd single-entry VC buffers
module pe_input #(
    parameter int DATA_WIDTH = 64,
    parameter int DIR_BIT    = 62
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       polarity,
    pe_input_if.slave  pe
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t            state_e, state_e_nxt;
    buf_state_t            state_o, state_o_nxt;
    logic                  dir_e, dir_o;
    logic [DATA_WIDTH-1:0] data_e, data_o;
    logic                  err_q;

    logic peri_c;
    logic write_e, write_o;
    logic rel_e, rel_o;
    logic ovf;

    // polarity=0 lets the PE write even while odd forwards, and vice versa
    assign peri_c  = !rst && (polarity ? (state_o == EMPTY) : (state_e == EMPTY));
    assign write_e = pe.pesi && peri_c && !polarity;
    assign write_o = pe.pesi && peri_c &&  polarity;
    assign ovf     = pe.pesi && !peri_c && !rst;

    // Only the grant matching the stored direction frees a buffer; polarity is irrelevant here
    assign rel_e = (state_e == FULL) && (dir_e ? pe.grant_ccw_even : pe.grant_cw_even);
    assign rel_o = (state_o == FULL) && (dir_o ? pe.grant_ccw_odd  : pe.grant_cw_odd);

    always_comb begin
        state_e_nxt = state_e;
        state_o_nxt = state_o;
        if (rel_e)   state_e_nxt = EMPTY;
        if (write_e) state_e_nxt = FULL;
        if (rel_o)   state_o_nxt = EMPTY;
        if (write_o) state_o_nxt = FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_e <= EMPTY;
            state_o <= EMPTY;
            dir_e   <= 1'b0;
            dir_o   <= 1'b0;
            data_e  <= '0;
            data_o  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_e <= state_e_nxt;
            state_o <= state_o_nxt;
            if (write_e) begin
                data_e <= pe.pedi;
                dir_e  <= pe.pedi[DIR_BIT];
            end
            if (write_o) begin
                data_o <= pe.pedi;
                dir_o  <= pe.pedi[DIR_BIT];
            end
            if (ovf) err_q <= 1'b1;
        end
    end

    assign pe.peri             = peri_c;
    assign pe.request_cw_even  = (state_e == FULL) && !dir_e &&  polarity;
    assign pe.request_ccw_even = (state_e == FULL) &&  dir_e &&  polarity;
    assign pe.request_cw_odd   = (state_o == FULL) && !dir_o && !polarity;
    assign pe.request_ccw_odd  = (state_o == FULL) &&  dir_o && !polarity;
    assign pe.data_out_even    = data_e;
    assign pe.data_out_odd     = data_o;
    assign pe.err_ovf          = err_q;
endmodule

// File: tb/tb_pe_input.sv
// tb/tb_pe_input.sv - scoreboard bench for pe_input
module tb_pe_input;
    logic clk = 1'b0;
    logic rst;
    logic polarity;

    always #5 clk = ~clk;

    pe_input_if #(.DATA_WIDTH(64)) bus ();

    pe_input #(.DATA_WIDTH(64), .DIR_BIT(62)) dut (
        .clk      (clk),
        .rst      (rst),
        .polarity (polarity),
        .pe       (bus)
    );

    typedef struct packed {
        logic        vc;
        logic        dir;
        logic [63:0] data;
    } sb_t;

    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;
    logic auto_gnt;
    logic [3:0] last_req;
    logic [3:0] req;

    // bit index = vc*2 + dir: 0 cw_even, 1 ccw_even, 2 cw_odd, 3 ccw_odd
    assign req = {bus.request_ccw_odd, bus.request_cw_odd, bus.request_ccw_even, bus.request_cw_even};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_grants(input logic [3:0] g);
        bus.grant_cw_even  = g[0];
        bus.grant_ccw_even = g[1];
        bus.grant_cw_odd   = g[2];
        bus.grant_ccw_odd  = g[3];
    endtask

    // One clock: drive inputs, check peri, grant/score requests, then step past the edge
    task automatic cycle(input logic pol, input logic send, input logic [63:0] d,
                         input logic exp_peri, input logic [3:0] g);
        logic [3:0] gv;
        sb_t        e;
        polarity = pol;
        bus.pesi = send;
        bus.pedi = d;
        drive_grants(4'b0000);
        #1;
        check("peri", 64'(bus.peri), 64'(exp_peri));
        if (send && exp_peri) sb.push_back('{vc: pol, dir: d[62], data: d});
        last_req = req;
        gv = g;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (auto_gnt || g[i])) begin
                check("sb_avail", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("req_line", 64'(i), 64'({e.vc, e.dir}));
                    check("data_out", (i >= 2) ? bus.data_out_odd : bus.data_out_even, e.data);
                end
                gv[i] = 1'b1;
            end
        end
        drive_grants(gv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.pesi = 1'b0;
        drive_grants(4'b0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        polarity = 1'b0;
        auto_gnt = 1'b1;
        bus.pesi = 1'b1;
        bus.pedi = '1;
        drive_grants(4'b0000);

        // reset with pesi held high
        @(posedge clk);
        #1;
        check("rst_peri", 64'(bus.peri), 64'd0);
        check("rst_req", 64'(req), 64'd0);
        check("rst_dout_e", bus.data_out_even, 64'd0);
        check("rst_dout_o", bus.data_out_odd, 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.pesi = 1'b0;
        #1;
        check("rst_err", 64'(bus.err_ovf), 64'd0);

        // single cw inject on even
        cycle(1'b0, 1'b1, 64'h0000_0000_0000_00A5, 1'b1, 4'b0000);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("cw_even_req", 64'(last_req), 64'h1);
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("cw_even_dropped", 64'(last_req), 64'h0);
        check("dout_hold", bus.data_out_even, 64'h0000_0000_0000_00A5);

        // ccw on odd, wrong-direction grant ignored
        auto_gnt = 1'b0;
        cycle(1'b1, 1'b1, 64'h4000_0000_0000_0003, 1'b1, 4'b0000);
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 4'b0100);
        check("ccw_odd_req", 64'(last_req), 64'h8);
        cycle(1'b1, 1'b0, 64'd0, 1'b0, 4'b0000);
        check("ccw_odd_wphase", 64'(last_req), 64'h0);
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 4'b1000);
        check("ccw_odd_held", 64'(last_req), 64'h8);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("ccw_odd_released", 64'(last_req), 64'h0);

        // overflow while even is full and ungranted
        cycle(1'b0, 1'b1, 64'h0000_0000_0000_0011, 1'b1, 4'b0000);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("ovf_req", 64'(last_req), 64'h1);
        check("ovf_pre", 64'(bus.err_ovf), 64'd0);
        cycle(1'b0, 1'b1, 64'h0000_0000_0000_0022, 1'b0, 4'b0000);
        check("ovf_set", 64'(bus.err_ovf), 64'd1);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("ovf_dout", bus.data_out_even, 64'h0000_0000_0000_0011);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 4'b0000);
        check("ovf_sticky", 64'(bus.err_ovf), 64'd1);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 4'b0001);
        check("ovf_sticky2", 64'(bus.err_ovf), 64'd1);
        do_reset();
        check("ovf_cleared", 64'(bus.err_ovf), 64'd0);

        // back-to-back streaming with toggling polarity
        auto_gnt = 1'b1;
        cycle(1'b0, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 4'b0000);
        cycle(1'b1, 1'b1, 64'h4000_0000_0000_0002, 1'b1, 4'b0000);
        cycle(1'b0, 1'b1, 64'h0000_0000_0000_0003, 1'b1, 4'b0000);
        cycle(1'b1, 1'b1, 64'h4000_0000_0000_0004, 1'b1, 4'b0000);
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("stream_drained", 64'(sb.size()), 64'd0);
        check("stream_err", 64'(bus.err_ovf), 64'd0);

        // reset mid-operation with both buffers full
        auto_gnt = 1'b0;
        cycle(1'b0, 1'b1, 64'h0000_0000_0000_AAAA, 1'b1, 4'b0000);
        cycle(1'b1, 1'b1, 64'h4000_0000_0000_BBBB, 1'b1, 4'b0000);
        check("mid_req", 64'(last_req), 64'h1);
        do_reset();
        sb.delete();
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("mid_req_e", 64'(last_req), 64'h0);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("mid_req_o", 64'(last_req), 64'h0);
        auto_gnt = 1'b1;
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 4'b0000);
        cycle(1'b1, 1'b0, 64'd0, 1'b1, 4'b0000);
        check("mid_dout_e", bus.data_out_even, 64'd0);
        check("mid_dout_o", bus.data_out_odd, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
